vram_pixel_writer: RTL and testbench
====================================

# vram_pixel_writer

Write-side front end of the 800x600 frame buffer. Accepts a raster-ordered RGB pixel stream from the Mandelbrot renderer over a valid/ready handshake, buffers it in a small FIFO, and issues VRAM write transactions with row/column addresses. Stored data is bit-inverted by default so the scan-out path, which inverts on read, displays the true colour. Frame alignment is tracked with a start-of-frame marker; misalignment is detected and resynchronised.

## Interface
- H_VIS, 800, visible columns per row
- V_VIS, 600, visible rows per frame
- FIFO_DEPTH, 4, input FIFO entries; power of two, >= 2
- INVERT, 1, 1: store ~pix_data; 0: store pix_data unchanged

- clock  in  1  single clock for all logic
- reset  in  1  asynchronous, active-high
- pix_valid  in  1  producer has a pixel
- pix_ready  out  1  block can accept a pixel
- pix_data  in  24  {R[23:16], G[15:8], B[7:0]}
- pix_sof  in  1  pixel is row 0, col 0 of a frame
- vram_wr_en  out  1  write request
- vram_wr_ready  in  1  VRAM accepts the write this cycle
- vram_wr_row  out  10  write row, 0..V_VIS-1
- vram_wr_col  out  10  write column, 0..H_VIS-1
- vram_wr_data  out  24  write data
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is written
- sync_error  out  1  one-cycle pulse on an unexpected pix_sof

## Operation
- Input transfer: pix_valid && pix_ready at a rising edge. {pix_sof, pix_data} is pushed to the FIFO.
- pix_ready = FIFO not full, from the registered count. There is no full-FIFO bypass: a pop on a full FIFO does not allow a same-cycle push.
- Write transfer: vram_wr_en && vram_wr_ready. The FIFO head is popped and the position advances.
- vram_wr_data = INVERT ? ~head_data : head_data.
- vram_wr_row/col come from the registered position counters.
- Position advance: col+1. At col == H_VIS-1, col <= 0 and row+1. At (V_VIS-1, H_VIS-1), the frame completes.
- States:
  - IDLE: vram_wr_en = 0; position held at (0,0).
    - Head present with sof = 0: popped and discarded; nothing is written.
    - Head present with sof = 1: not popped; next state is WRITE.
  - WRITE, head present with sof = 0, or sof = 1 at position (0,0): vram_wr_en = 1.
  - WRITE, head with sof = 1 at position != (0,0):
    - vram_wr_en = 0, no pop, sync_error pulses.
    - Position <= (0,0); the pixel is written at (0,0) on a following cycle.
  - WRITE, write transfer at (V_VIS-1, H_VIS-1):
    - Position <= (0,0), next state is IDLE.
    - frame_done pulses in the following cycle.
- Once vram_wr_en is asserted, it and row/col/data stay stable until vram_wr_ready.
- Reset mid-operation:
  - FIFO flushed, state goes to IDLE, position goes to (0,0).
  - frame_done and sync_error are not pulsed.
  - Partial frame contents in VRAM are left as is.

## Timing
- Reset values:
  - pix_ready 1.
  - vram_wr_en, frame_done, sync_error 0.
  - vram_wr_row, vram_wr_col 0.
  - vram_wr_data = INVERT ? 24'hFFFFFF : 0.
  - FIFO empty, state IDLE.
- Latency in WRITE with an empty FIFO: pixel accepted at edge N, vram_wr_en high in cycle N+1.
- Latency for sof from IDLE: accepted at edge N, state goes to WRITE at edge N+1, first vram_wr_en in cycle N+2.
- Throughput: 1 pixel/cycle sustained when vram_wr_ready is held at 1.
- frame_done is registered: it is high for exactly the cycle after the final write handshake.
- sync_error is high for exactly the cycle in which the misaligned sof is at the head in WRITE.
- Counter widths:
  - Row and col are 10 bits and never exceed V_VIS-1 / H_VIS-1.
  - FIFO count is log2(FIFO_DEPTH)+1 bits.

## Test plan
- Full frame:
  - Stimulus: reset; 480000 pixels, sof on the first, data 24'h123456, vram_wr_ready = 1.
  - Required: 480000 writes, all with data 24'hEDCBA9; last write at (599,799); one frame_done pulse one cycle after it; no sync_error; back in IDLE.
- Pre-sof junk:
  - Stimulus: 5 pixels with sof = 0, then a frame starting with sof.
  - Required: zero writes for the junk; first write at (0,0) with the sof pixel's data.
- Backpressure:
  - Stimulus: vram_wr_ready held low for 10 cycles while pix_valid stays high.
  - Required: exactly 4 pixels accepted before pix_ready = 0; vram_wr_* stable throughout; on release, the pixels are written in order at consecutive addresses with no loss.
- Column/row wrap:
  - Stimulus: after sof, the 801st pixel of the frame.
  - Required: that pixel is written at row 1, col 0.
- Early sof:
  - Stimulus: sof arrives when the position is (2,5).
  - Required: sync_error for 1 cycle; no write that cycle; next write at (0,0) with the sof data; the frame then completes normally.
- Reset mid-frame:
  - Stimulus: assert reset at position (100,100) with 3 pixels in the FIFO.
  - Required: all outputs return to their reset values; no frame_done; the next sof pixel is written at (0,0).

Source files
------------

// File: rtl/vram_pixel_writer_if.sv
// Bundle of the pixel-stream input and VRAM write-request output of vram_pixel_writer.
// Both handshakes are strict valid/ready: a beat transfers on a rising edge where the
// sender's valid (pix_valid / vram_wr_en) and the receiver's ready are both high; once
// raised, valid and its payload stay stable until that transfer happens.
interface vram_pixel_writer_if;
    logic        pix_valid;
    logic        pix_ready;
    logic [23:0] pix_data;
    logic        pix_sof;
    logic        vram_wr_en;
    logic        vram_wr_ready;
    logic [9:0]  vram_wr_row;
    logic [9:0]  vram_wr_col;
    logic [23:0] vram_wr_data;
    logic        frame_done;
    logic        sync_error;

    // master: the pixel writer itself; slave: renderer + VRAM side
    modport master (
        input  pix_valid, pix_data, pix_sof, vram_wr_ready,
        output pix_ready, vram_wr_en, vram_wr_row, vram_wr_col, vram_wr_data,
        output frame_done, sync_error
    );

    modport slave (
        output pix_valid, pix_data, pix_sof, vram_wr_ready,
        input  pix_ready, vram_wr_en, vram_wr_row, vram_wr_col, vram_wr_data,
        input  frame_done, sync_error
    );
endinterface

// File: rtl/vram_pixel_writer.sv
// Write-side front end of the frame buffer: buffers a raster pixel stream in a small
// FIFO and turns it into row/column-addressed VRAM writes, realigning on start-of-frame.
module vram_pixel_writer #(
    parameter int H_VIS      = 800,
    parameter int V_VIS      = 600,
    parameter int FIFO_DEPTH = 4,
    parameter bit INVERT     = 1'b1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    vram_pixel_writer_if.master  if_bus,
    output logic                 o_state
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [9:0]    LAST_COL = 10'(H_VIS - 1);
    localparam logic [9:0]    LAST_ROW = 10'(V_VIS - 1);

    typedef enum logic {ST_IDLE = 1'b0, ST_WRITE = 1'b1} state_t;

    state_t        r_state;
    state_t        w_next_state;

    logic [24:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic [9:0]    r_row;
    logic [9:0]    r_col;
    logic          r_frame_done;

    logic          w_pix_ready;
    logic          w_push;
    logic          w_pop;
    logic          w_head_vld;
    logic          w_head_sof;
    logic [23:0]   w_head_data;
    logic          w_wr_en;
    logic          w_sync_error;
    logic          w_pos_clear;
    logic          w_pos_adv;
    logic          w_at_origin;
    logic          w_at_eol;
    logic          w_at_last;

    // Ready comes from the registered count only, so a full FIFO never takes a
    // same-cycle push even when the head is being popped.
    assign w_pix_ready = (r_count != FULL_CNT);
    assign w_push      = if_bus.pix_valid && w_pix_ready;
    assign w_head_vld  = (r_count != '0);
    assign w_head_sof  = w_head_vld && r_mem[r_rd_ptr][24];
    assign w_head_data = w_head_vld ? r_mem[r_rd_ptr][23:0] : 24'h000000;

    assign w_at_origin = (r_row == 10'd0) && (r_col == 10'd0);
    assign w_at_eol    = (r_col == LAST_COL);
    assign w_at_last   = w_at_eol && (r_row == LAST_ROW);

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {if_bus.pix_sof, if_bus.pix_data};
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_wr_en      = 1'b0;
        w_pop        = 1'b0;
        w_sync_error = 1'b0;
        w_pos_clear  = 1'b0;
        w_pos_adv    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Anything before a start-of-frame is discarded; the sof pixel stays
                // at the head so WRITE emits it at (0,0).
                w_pos_clear = 1'b1;
                if (w_head_vld) begin
                    if (w_head_sof) begin
                        w_next_state = ST_WRITE;
                    end else begin
                        w_pop = 1'b1;
                    end
                end
            end
            ST_WRITE: begin
                if (w_head_vld) begin
                    if (w_head_sof && !w_at_origin) begin
                        w_sync_error = 1'b1;
                        w_pos_clear  = 1'b1;
                    end else begin
                        w_wr_en = 1'b1;
                        if (if_bus.vram_wr_ready) begin
                            w_pop     = 1'b1;
                            w_pos_adv = 1'b1;
                            if (w_at_last) begin
                                w_next_state = ST_IDLE;
                            end
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_row <= 10'd0;
            r_col <= 10'd0;
        end else if (w_pos_clear) begin
            r_row <= 10'd0;
            r_col <= 10'd0;
        end else if (w_pos_adv) begin
            if (w_at_eol) begin
                r_col <= 10'd0;
                r_row <= (r_row == LAST_ROW) ? 10'd0 : r_row + 10'd1;
            end else begin
                r_col <= r_col + 10'd1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_pos_adv && w_at_last;
        end
    end

    // Scan-out inverts on read, so storing the complement shows the true colour.
    assign if_bus.vram_wr_data = INVERT ? ~w_head_data : w_head_data;
    assign if_bus.pix_ready    = w_pix_ready;
    assign if_bus.vram_wr_en   = w_wr_en;
    assign if_bus.vram_wr_row  = r_row;
    assign if_bus.vram_wr_col  = r_col;
    assign if_bus.frame_done   = r_frame_done;
    assign if_bus.sync_error   = w_sync_error;
    assign o_state             = r_state;
endmodule

// File: tb/tb_vram_pixel_writer.sv
// Self-checking bench for vram_pixel_writer; frame geometry is reduced to 16x8 so
// each frame is about a hundred cycles.
module tb_vram_pixel_writer;
    localparam int H   = 16;
    localparam int V   = 8;
    localparam int FD  = 4;
    localparam bit INV = 1'b1;
    localparam int W   = 44;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic st;

    vram_pixel_writer_if bus ();

    vram_pixel_writer #(
        .H_VIS(H), .V_VIS(V), .FIFO_DEPTH(FD), .INVERT(INV)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .if_bus(bus),
        .o_state(st)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int acc_cnt = 0;
    int wr_cnt  = 0;
    int exp_fd  = 0;
    int obs_fd  = 0;
    int exp_sync = 0;
    int obs_sync = 0;
    int cyc = 0;
    int first_wr_cyc = 0;
    int last_wr_cyc = 0;
    int rdy_mode = 0;
    logic m_in = 1'b0;
    int m_row = 0;
    int m_col = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_e;
    logic fd_pend = 1'b0;
    logic hold_v = 1'b0;
    logic [W:0] hold_val;
    logic [9:0] last_row, last_col, wrap_row, wrap_col;
    logic [23:0] last_data;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic cycle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // VRAM ready driver
    initial begin
        bus.vram_wr_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus.vram_wr_ready = 1'b1;
                1:       bus.vram_wr_ready = 1'($urandom_range(0, 1));
                default: bus.vram_wr_ready = 1'b0;
            endcase
        end
    end

    // Monitor + reference model of the accepted pixel stream
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            fd_pend = 1'b0;
            hold_v  = 1'b0;
        end else begin
            if (fd_pend || bus.frame_done) check("frame_done_timing", 64'(bus.frame_done), 64'(fd_pend));
            if (bus.frame_done) obs_fd++;
            if (bus.sync_error) begin
                obs_sync++;
                check("sync_no_write", 64'(bus.vram_wr_en), 64'd0);
            end
            if (hold_v) check("stall_stable",
                64'({bus.vram_wr_en, bus.vram_wr_row, bus.vram_wr_col, bus.vram_wr_data}), 64'(hold_val));
            hold_v   = bus.vram_wr_en && !bus.vram_wr_ready;
            hold_val = {bus.vram_wr_en, bus.vram_wr_row, bus.vram_wr_col, bus.vram_wr_data};
            fd_pend  = 1'b0;
            if (bus.vram_wr_en && bus.vram_wr_ready) begin
                wr_cnt++;
                if (wr_cnt == 1) first_wr_cyc = cyc;
                last_wr_cyc = cyc;
                last_row  = bus.vram_wr_row;
                last_col  = bus.vram_wr_col;
                last_data = bus.vram_wr_data;
                if (wr_cnt == H + 1) begin
                    wrap_row = bus.vram_wr_row;
                    wrap_col = bus.vram_wr_col;
                end
                fd_pend = (bus.vram_wr_row == 10'(V - 1)) && (bus.vram_wr_col == 10'(H - 1));
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 64'({1'b1, bus.vram_wr_row, bus.vram_wr_col, bus.vram_wr_data}), 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("write", 64'({bus.vram_wr_row, bus.vram_wr_col, bus.vram_wr_data}), 64'(mon_e));
                end
            end
            if (bus.pix_valid && bus.pix_ready) begin
                acc_cnt++;
                if (bus.pix_sof) begin
                    if (m_in && (m_row != 0 || m_col != 0)) exp_sync++;
                    m_in = 1'b1;
                    m_row = 0;
                    m_col = 0;
                end
                if (m_in) begin
                    exp_q.push_back({10'(m_row), 10'(m_col), INV ? ~bus.pix_data : bus.pix_data});
                    if (m_col == H - 1) begin
                        m_col = 0;
                        if (m_row == V - 1) begin
                            m_row = 0;
                            m_in = 1'b0;
                            exp_fd++;
                        end else begin
                            m_row++;
                        end
                    end else begin
                        m_col++;
                    end
                end
            end
        end
    end

    task automatic send_px(input logic [23:0] d, input logic sof, input int gap);
        bit done;
        done = 1'b0;
        bus.pix_valid = 1'b1;
        bus.pix_data  = d;
        bus.pix_sof   = sof;
        for (int t = 0; t < 500 && !done; t++) begin
            @(negedge clk);
            done = bus.pix_ready;
            @(posedge clk);
            #1;
        end
        bus.pix_valid = 1'b0;
        bus.pix_sof   = 1'b0;
        if (!done) check("send_timeout", 64'd0, 64'd1);
        cycle(gap);
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 2000; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !bus.vram_wr_en) break;
        end
        cycle(1);
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_reset();
        check("rst_pix_ready", 64'(bus.pix_ready), 64'd1);
        check("rst_wr_en", 64'(bus.vram_wr_en), 64'd0);
        check("rst_frame_done", 64'(bus.frame_done), 64'd0);
        check("rst_sync_error", 64'(bus.sync_error), 64'd0);
        check("rst_row", 64'(bus.vram_wr_row), 64'd0);
        check("rst_col", 64'(bus.vram_wr_col), 64'd0);
        check("rst_data", 64'(bus.vram_wr_data), INV ? 64'hFFFFFF : 64'h0);
        check("rst_state", 64'(st), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        int fd0;
        logic [23:0] d;
        bit acc;
        bus.pix_valid = 1'b0;
        bus.pix_data  = 24'h0;
        bus.pix_sof   = 1'b0;
        cycle(3);
        check_reset();
        rst = 1'b0;
        cycle(2);

        // Junk before any sof is dropped
        for (int i = 0; i < 5; i++) send_px(24'($urandom), 1'b0, 0);
        cycle(4);
        check("junk_writes", 64'(wr_cnt), 64'd0);
        check("junk_state", 64'(st), 64'd0);

        // Full frame of constant data at full rate
        for (int i = 0; i < H * V; i++) send_px(24'h123456, i == 0, 0);
        wait_drain();
        cycle(2);
        check("f1_last_row", 64'(last_row), 64'(V - 1));
        check("f1_last_col", 64'(last_col), 64'(H - 1));
        check("f1_last_data", 64'(last_data), 64'hEDCBA9);
        check("f1_writes", 64'(wr_cnt), 64'(H * V));
        check("f1_throughput", 64'(last_wr_cyc - first_wr_cyc), 64'(H * V - 1));
        check("wrap_row", 64'(wrap_row), 64'd1);
        check("wrap_col", 64'(wrap_col), 64'd0);
        check("f1_frame_done", 64'(obs_fd), 64'd1);
        check("f1_sync", 64'(obs_sync), 64'd0);
        check("f1_idle", 64'(st), 64'd0);

        // Random frame with a forced backpressure window
        rdy_mode = 1;
        for (int i = 0; i < 20; i++) send_px(24'($urandom), i == 0, $urandom_range(0, 1));
        wait_drain();
        rdy_mode = 2;
        cycle(2);
        a0 = acc_cnt;
        d = 24'($urandom);
        for (int i = 0; i < 10; i++) begin
            bus.pix_valid = 1'b1;
            bus.pix_data  = d;
            @(negedge clk);
            acc = bus.pix_ready;
            @(posedge clk);
            #1;
            if (acc) d = 24'($urandom);
        end
        bus.pix_valid = 1'b0;
        check("bp_accepted", 64'(acc_cnt - a0), 64'd4);
        check("bp_ready_low", 64'(bus.pix_ready), 64'd0);
        check("bp_wr_en", 64'(bus.vram_wr_en), 64'd1);
        rdy_mode = 1;
        for (int i = 0; i < H * V - 24; i++) send_px(24'($urandom), 1'b0, $urandom_range(0, 1));
        wait_drain();
        cycle(2);
        check("f2_frame_done", 64'(obs_fd), 64'd2);

        // Early sof at (2,5)
        rdy_mode = 0;
        for (int i = 0; i < 2 * H + 5; i++) send_px(24'($urandom), i == 0, 0);
        wait_drain();
        check("early_row", 64'(bus.vram_wr_row), 64'd2);
        check("early_col", 64'(bus.vram_wr_col), 64'd5);
        for (int i = 0; i < H * V; i++) send_px(24'($urandom), i == 0, 0);
        wait_drain();
        cycle(2);
        check("early_sync", 64'(obs_sync), 64'd1);
        check("early_frame_done", 64'(obs_fd), 64'd3);

        // Reset at (3,10) with 3 pixels buffered
        for (int i = 0; i < 3 * H + 10; i++) send_px(24'($urandom), i == 0, 0);
        wait_drain();
        rdy_mode = 2;
        cycle(2);
        for (int i = 0; i < 3; i++) send_px(24'($urandom), 1'b0, 0);
        check("pre_rst_row", 64'(bus.vram_wr_row), 64'd3);
        check("pre_rst_col", 64'(bus.vram_wr_col), 64'd10);
        check("pre_rst_wr_en", 64'(bus.vram_wr_en), 64'd1);
        rst = 1'b1;
        #1;
        check_reset();
        fd0 = obs_fd;
        exp_q.delete();
        m_in = 1'b0;
        m_row = 0;
        m_col = 0;
        cycle(2);
        rst = 1'b0;
        rdy_mode = 0;
        cycle(3);
        check("rst_no_frame_done", 64'(obs_fd), 64'(fd0));
        for (int i = 0; i < H * V; i++) send_px(24'($urandom), i == 0, 0);
        wait_drain();
        cycle(2);

        check("final_queue", 64'(exp_q.size()), 64'd0);
        check("final_frame_done", 64'(obs_fd), 64'(exp_fd));
        check("final_frames", 64'(obs_fd), 64'd4);
        check("final_sync", 64'(obs_sync), 64'(exp_sync));
        check("final_state", 64'(st), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
